vga_fb_arb: RTL and testbench

Single-port framebuffer arbiter between the VGA display read path and a pixel writer. It sits between `vga_ctrl` and a synchronous-read RGB565 framebuffer RAM. Display fetches driven by `pix_x`/`pix_y` always win the port. Writer requests are queued in a small FIFO and retired on cycles the display leaves idle, mainly horizontal and vertical blanking.

---
 rtl/vga_fb_arb.sv | 116 +++++++++++
 tb/tb_vga_fb_arb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arb.sv
// Single-port framebuffer arbiter: display fetches always own the RAM port, queued
// writer requests retire on cycles the display leaves idle. Define VGA_FB_ARB_STAT_EN for stall_cnt.
module vga_fb_arb #(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              vga_clk,
    input  logic              sys_rst,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    output logic [15:0]       pix_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata
`ifdef VGA_FB_ARB_STAT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned ENT_W = ADDR_W + 16;

    typedef enum logic [1:0] {IDLE, DISP, WRITE} own_e;
    own_e state_q, state_d;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [ENT_W-1:0]  fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic              push, pop, fifo_empty;
    logic [ENT_W-1:0]  head;

    assign disp_req  = (32'(pix_x) < H_RES) && (32'(pix_y) < V_RES);
    assign disp_addr = ADDR_W'(32'(pix_y) * H_RES + 32'(pix_x));

    assign fifo_empty = (cnt_q == '0);
    assign wr_ready   = (cnt_q != (PTR_W+1)'(FIFO_DEPTH));
    assign head       = fifo_q[rd_ptr_q];
    assign push       = wr_valid && wr_ready;
    assign pop        = (state_d == WRITE);

    // Owner of this cycle is decided combinationally so a display fetch never waits;
    // reset forces IDLE so the write strobe drops without waiting for a clock.
    always_comb begin
        state_d = IDLE;
        if (!sys_rst) begin
            if (disp_req)         state_d = DISP;
            else if (!fifo_empty) state_d = WRITE;
        end
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state_d)
            DISP:  mem_addr = disp_addr;
            WRITE: begin
                mem_addr  = head[ENT_W-1:16];
                mem_wdata = head[15:0];
                mem_we    = 1'b1;
            end
            default: ;
        endcase
    end

    // state_q == DISP is the registered display request, aligned with RAM read latency.
    assign pix_data = (state_q == DISP) ? mem_rdata : 16'h0000;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (push) fifo_q[wr_ptr_q] <= {wr_addr, wr_data};
    end

`ifdef VGA_FB_ARB_STAT_EN
    logic [15:0] stall_q;

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst)                                        stall_q <= '0;
        else if (pix_x == 10'd0 && pix_y == 10'd0)          stall_q <= '0;
        else if (wr_valid && !wr_ready && stall_q != 16'hffff) stall_q <= stall_q + 1'b1;
    end

    assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_vga_fb_arb.sv
// Randomized scoreboard bench for vga_fb_arb: stimulus pushes per-cycle and per-write
// expectations from a queue-based model; a negedge monitor pops and compares.
module tb_vga_fb_arb;
    localparam int H     = 640;
    localparam int V     = 480;
    localparam int AW    = 19;
    localparam int DEPTH = 16;

    logic          vga_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [9:0]    pix_x = 10'h3ff, pix_y = 10'h3ff;
    logic [15:0]   pix_data;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [15:0]   wr_data = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata = '0;
`ifdef VGA_FB_ARB_STAT_EN
    logic [15:0]   stall_cnt;
`endif

    vga_fb_arb #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .vga_clk(vga_clk), .sys_rst(sys_rst), .pix_x(pix_x), .pix_y(pix_y),
        .pix_data(pix_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef VGA_FB_ARB_STAT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        bit            ready;
        bit            disp;
        bit            we;
        logic [AW-1:0] daddr;
        logic [15:0]   pix;
        logic [15:0]   stall;
    } exp_t;

    exp_t             expq[$];
    logic [AW+15:0]   wrq[$];
    int               total = 0;
    int               bad = 0;
    int               pend = 0;
    bit               prev_disp = 0;
    logic [15:0]      stall_m = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One modelled cycle: drive inputs just after the edge and record what the
    // arbiter must do under the rules (display wins, oldest write retires when free).
    task automatic cycle(input int x, input int y, input bit v,
                         input logic [AW-1:0] a, input logic [15:0] d);
        exp_t        e;
        logic [15:0] rd;
        bit          disp, rdy, we;
        @(posedge vga_clk);
        #1;
        rd = 16'($urandom);
        pix_x = 10'(x); pix_y = 10'(y);
        wr_valid = v; wr_addr = a; wr_data = d; mem_rdata = rd;
        disp = (x < H) && (y < V);
        rdy  = (pend < DEPTH);
        we   = !disp && (pend > 0);
        e.ready = rdy; e.disp = disp; e.we = we;
        e.daddr = AW'(y * H + x);
        e.pix   = prev_disp ? rd : 16'h0000;
        e.stall = stall_m;
        expq.push_back(e);
        if (we) pend--;
        if (v && rdy) begin
            wrq.push_back({a, d});
            pend++;
        end
        prev_disp = disp;
        if (x == 0 && y == 0)                            stall_m = '0;
        else if (v && !rdy && stall_m != 16'hffff)       stall_m = stall_m + 16'd1;
    endtask

    task automatic rcycle(input int x, input int y, input bit v);
        cycle(x, y, v, AW'($urandom), 16'($urandom));
    endtask

    task automatic mid_reset();
        @(posedge vga_clk);
        #1;
        sys_rst = 1'b1; wr_valid = 1'b0; pix_x = 10'h3ff; pix_y = 10'h3ff;
        #1;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        wrq.delete();
        pend = 0; prev_disp = 0; stall_m = '0;
        repeat (2) @(posedge vga_clk);
        #1 sys_rst = 1'b0;
    endtask

    always @(negedge vga_clk) begin
        exp_t           e;
        logic [AW+15:0] w;
        if (!sys_rst && expq.size() > 0) begin
            e = expq.pop_front();
            chk("wr_ready", 32'(wr_ready), 32'(e.ready));
            chk("pix_data", 32'(pix_data), 32'(e.pix));
            chk("mem_we", 32'(mem_we), 32'(e.we));
            if (e.disp) begin
                chk("disp_addr", 32'(mem_addr), 32'(e.daddr));
            end else if (mem_we) begin
                total++;
                if (wrq.size() == 0) begin
                    bad++;
                    $display("FAIL wr_order: got write %0h/%0h want none queued", mem_addr, mem_wdata);
                end else begin
                    w = wrq.pop_front();
                    total--;
                    chk("wr_addr", 32'(mem_addr), 32'(w[AW+15:16]));
                    chk("wr_data", 32'(mem_wdata), 32'(w[15:0]));
                end
            end else begin
                chk("idle_addr", 32'(mem_addr), 32'd0);
                chk("idle_wdata", 32'(mem_wdata), 32'd0);
            end
`ifdef VGA_FB_ARB_STAT_EN
            chk("stall_cnt", 32'(stall_cnt), 32'(e.stall));
`endif
        end
    end

    initial begin
        int x, y, r;
        #2;
        chk("reset_pix_data", 32'(pix_data), 32'd0);
        chk("reset_wr_ready", 32'(wr_ready), 32'd1);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
`ifdef VGA_FB_ARB_STAT_EN
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        @(posedge vga_clk);
        #1 sys_rst = 1'b0;
        repeat (2) rcycle(1023, 1023, 0);

        // display read at (3,2), then no request
        rcycle(3, 2, 0);
        #1;
        chk("read_addr_1283", 32'(mem_addr), 32'd1283);
        chk("read_we", 32'(mem_we), 32'd0);
        rcycle(1023, 1023, 0);
        rcycle(1023, 1023, 0);

        // blanking write goes out the following cycle
        cycle(1023, 1023, 1, 19'h00010, 16'h07e0);
        rcycle(1023, 1023, 0);
        #1;
        chk("blank_we", 32'(mem_we), 32'd1);
        chk("blank_addr", 32'(mem_addr), 32'h10);
        chk("blank_wdata", 32'(mem_wdata), 32'h07e0);
        rcycle(1023, 1023, 0);

        // preemption: three writes held off by 10 display cycles
        for (int i = 0; i < 10; i++) rcycle(100 + i, 7, (i == 1 || i == 4 || i == 8));
        repeat (5) rcycle(1023, 1023, 0);

        // full FIFO during active video, then stall accounting
        rcycle(0, 0, 0);
        for (int i = 0; i < 16; i++) rcycle(i, 1, 1);
        for (int i = 0; i < 40; i++) rcycle(16 + i, 1, 1);
        rcycle(700, 1, 0);
`ifdef VGA_FB_ARB_STAT_EN
        chk("stall_40", 32'(stall_cnt), 32'd40);
`endif
        rcycle(0, 0, 0);
        rcycle(1023, 1023, 0);
`ifdef VGA_FB_ARB_STAT_EN
        chk("stall_frame_clear", 32'(stall_cnt), 32'd0);
`endif
        repeat (20) rcycle(1023, 1023, 0);

        // reset with five pending writes
        for (int i = 0; i < 5; i++) rcycle(50 + i, 3, 1);
        mid_reset();
        repeat (5) rcycle(1023, 1023, 0);

        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 9));
            x = (r < 6) ? int'($urandom_range(0, 639)) : (r < 8) ? 1023 : int'($urandom_range(640, 1022));
            r = int'($urandom_range(0, 9));
            y = (r < 7) ? int'($urandom_range(0, 479)) : (r < 8) ? 1023 : int'($urandom_range(480, 1022));
            if ($urandom_range(0, 199) == 0) begin x = 0; y = 0; end
            rcycle(x, y, ($urandom_range(0, 9) < 7));
        end

        repeat (30) rcycle(1023, 1023, 0);
        @(negedge vga_clk);
        #1;
        chk("drain_empty", 32'(wrq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
